vga_timing_compositor: RTL and testbench
========================================

Name: vga_timing_compositor

Overview:
- Generates 640x480@60 VGA raster timing: pixel coordinates x, y and the active flag.
- Feeds those coordinates to the combinational overlay generators (emblem and similar).
- Consumes each generator's 6-bit RGB222 result and keys out the transparent code 6'b100001 against a background colour.
- Drives registered, pin-aligned rgb/hsync/vsync to the output pins, plus line and frame strobes for animation logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE_HIGH, 0, 0 = sync pulses drive low, 1 = drive high
- KEY_COLOR, 6'b100001, overlay code treated as transparent

Ports:
- clk  input  1  pixel clock (25.175 MHz nominal)
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  clock enable; low freezes all state
- x  output  10  horizontal counter h_cnt, 0..799
- y  output  10  vertical counter v_cnt, 0..524
- active  output  1  (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE), combinational from counters
- ovl_rgb  input  6  overlay colour for the current x,y (same cycle, combinational upstream)
- bg_rgb  input  6  background colour for the current x,y
- rgb_out  output  6  registered pixel to pins
- hsync  output  1  registered horizontal sync
- vsync  output  1  registered vertical sync
- line_tick  output  1  registered 1-cycle pulse at start of each line
- frame_tick  output  1  registered 1-cycle pulse at start of each frame
- frame_count  output  8  frame counter (see Optional Feature)

Behaviour:
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
  - When ena=1, h_cnt increments each clk and wraps H_TOTAL-1 -> 0.
  - On h wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - x and y are the raw counters; they are not gated by active.
- Sync decode (combinational):
  - hs_c is true for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_c is true for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- Output stage: one register, latency 1 clk from counter state. On each clk with ena=1:
  - rgb_out <= !active ? 0 : (ovl_rgb == KEY_COLOR ? bg_rgb : ovl_rgb)
  - hsync <= hs_c XOR !SYNC_ACTIVE_HIGH
  - vsync <= vs_c XOR !SYNC_ACTIVE_HIGH
  - line_tick <= (h_cnt == H_TOTAL-1)
  - frame_tick <= (h_cnt == H_TOTAL-1) && (v_cnt == V_TOTAL-1)
  - Result: line_tick is high in the cycle where h_cnt == 0. frame_tick is high where h_cnt == 0 and v_cnt == 0; line_tick is also high in that cycle.
- Reset (async assert, sync release):
  - h_cnt = 0, v_cnt = 0, rgb_out = 0, line_tick = 0, frame_tick = 0, frame_count = 0.
  - hsync and vsync take their inactive level (1 when SYNC_ACTIVE_HIGH=0).
  - Reset asserted mid-line or mid-frame takes effect immediately. The first clk after release with ena=1 advances h_cnt to 1 and registers pixel (0,0).
- ena=0: counters, all output registers and frame_count hold their values; combinational x/y/active follow the held counters.
- Key compare is exact, 6-bit. KEY_COLOR is never emitted from an overlay; bg_rgb equal to KEY_COLOR is passed through unchanged.
- Blanking has priority over keying: outside active, rgb_out = 0 regardless of ovl_rgb and bg_rgb.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- When defined: 8-bit frame_count increments, modulo 256, in the same clk that registers frame_tick=1. It is reset to 0 by rst_n and holds when ena=0.
- When undefined: frame_count is tied to 8'd0 and no counter flops are synthesised.

Test Plan:
- Reset: hold rst_n=0 -> rgb_out=0, hsync=1, vsync=1, x=0, y=0, ticks=0. Release; after 10 enabled clks -> x=10, y=0, active=1.
- Hsync timing: count enabled clks from release. hsync pin is low exactly for the 96 clks in which registered h_cnt was 656..751, and low again 800 clks later. Repeat with SYNC_ACTIVE_HIGH=1 -> same window, polarity inverted.
- Vsync and ticks:
  - vsync is low for exactly 1600 clks, covering lines 490..491.
  - line_tick pulses every 800 clks.
  - frame_tick pulses every 420000 clks, coincident with x=0, y=0.
- Keying, at active pixel (100,50):
  - ovl=6'b100001, bg=6'b001100 -> next clk rgb_out=6'b001100.
  - ovl=6'b110110 -> rgb_out=6'b110110.
- Blanking: at x=640 with ovl=6'b111111 -> next clk rgb_out=0. At y=480, x=5 -> rgb_out=0.
- ena and reset:
  - Drop ena for 20 clks mid-line at x=300 -> x stays 300 and outputs hold; resume -> x=301.
  - Assert rst_n mid-frame at y=200 -> immediate zeroing.
  - With VGA_FRAME_COUNT_EN, 3 full frames -> frame_count=3.

Source files
------------

// File: rtl/vga_timing_compositor.sv
// -----------------------------------------------------------------------------
// vga_timing_compositor
//
// Purpose:
//   Generates 640x480@60 VGA raster timing. The raw horizontal and vertical
//   counters go out as x/y so that combinational overlay generators can compute
//   a colour for the current pixel. This block takes that overlay colour and
//   keys it against a background colour: the overlay code KEY_COLOR is
//   transparent. Blanking, sync and animation strobes are then registered in
//   one stage, so every pin changes on the same clock edge.
//
// Ports:
//   clk          pixel clock (25.175 MHz nominal)
//   rst_n        asynchronous active-low reset
//   ena          clock enable; low freezes all state
//   x, y         raw h/v counters (0..799, 0..524), not gated by active
//   active       combinational visible-area flag derived from x/y
//   ovl_rgb      overlay RGB222 colour for the current x,y
//   bg_rgb       background RGB222 colour for the current x,y
//   rgb_out      registered pixel colour, zero outside the visible area
//   hsync/vsync  registered sync pulses, polarity set by SYNC_ACTIVE_HIGH
//   line_tick    registered 1-cycle pulse while x == 0
//   frame_tick   registered 1-cycle pulse while x == 0 and y == 0
//   frame_count  8-bit frame counter
//
// Optional feature (macro VGA_FRAME_COUNT_EN):
//   When defined, frame_count increments modulo 256 on each frame_tick.
//   When undefined, frame_count is tied to zero and has no flops.
// -----------------------------------------------------------------------------
module vga_timing_compositor #(
  parameter int          H_ACTIVE         = 640,
  parameter int          H_FP             = 16,
  parameter int          H_SYNC           = 96,
  parameter int          H_BP             = 48,
  parameter int          V_ACTIVE         = 480,
  parameter int          V_FP             = 10,
  parameter int          V_SYNC           = 2,
  parameter int          V_BP             = 33,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b0,
  parameter logic [5:0]  KEY_COLOR        = 6'b100001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  input  logic [5:0] ovl_rgb,
  input  logic [5:0] bg_rgb,
  output logic [5:0] rgb_out,
  output logic       hsync,
  output logic       vsync,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  // This is the pin level when no sync pulse is running. It is also the reset value.
  localparam logic SYNC_IDLE = ~SYNC_ACTIVE_HIGH;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       hs_c;
  logic       vs_c;
  logic [5:0] pixel_c;

  assign x      = h_cnt;
  assign y      = v_cnt;
  assign active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);
  assign hs_c   = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_c   = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // Blanking wins over keying. A background colour that equals KEY_COLOR
  // passes through unchanged, because only the overlay is compared.
  always_comb begin
    // NOTE: default first, so no path leaves pixel_c unassigned (no latch).
    pixel_c = '0;
    if (active) begin
      pixel_c = (ovl_rgb == KEY_COLOR) ? bg_rgb : ovl_rgb;
    end
  end

  // Raster counters. v_cnt advances only on the h wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking for all sequential state, so every flop samples pre-edge values.
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ena) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Output stage. Its latency is one clock from the counter state, so the
  // strobes decoded at the last count of a line show up while h_cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out    <= '0;
      hsync      <= SYNC_IDLE;
      vsync      <= SYNC_IDLE;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else if (ena) begin
      rgb_out    <= pixel_c;
      hsync      <= hs_c ^ SYNC_IDLE;
      vsync      <= vs_c ^ SYNC_IDLE;
      line_tick  <= h_last;
      frame_tick <= h_last && v_last;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // The increment condition is the one that registers frame_tick=1, so
  // the count steps in the same edge that raises the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else if (ena && h_last && v_last) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_compositor.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_compositor
//
// Two instances share the same clock and stimulus: one has active-low sync,
// the other active-high. The vertical geometry is shortened (8/2/2/3 lines)
// so that several whole frames fit in a short run. The horizontal geometry
// stays at full size, so the 800-clock line and the 96-clock hsync keep their
// real lengths. The vsync pulse stays 2 lines (1600 clocks) long.
// -----------------------------------------------------------------------------
module tb_vga_timing_compositor;

  localparam int HT = 800;
  localparam int VA = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VA + VF + VS + VB;
  localparam logic [5:0] KEY = 6'b100001;

`ifdef VGA_FRAME_COUNT_EN
  localparam int FC_AFTER_3 = 3;
`else
  localparam int FC_AFTER_3 = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [5:0] ovl_rgb = '0;
  logic [5:0] bg_rgb = '0;

  logic [9:0] x, y, xb, yb;
  logic       active, active_b;
  logic [5:0] rgb_out, rgb_b;
  logic       hsync, vsync, line_tick, frame_tick;
  logic       hsync_b, vsync_b, lt_b, ft_b;
  logic [7:0] frame_count, fc_b;

  vga_timing_compositor #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE_HIGH(1'b0)
  ) dut_lo (
    .clk(clk), .rst_n(rst_n), .ena(ena), .x(x), .y(y), .active(active),
    .ovl_rgb(ovl_rgb), .bg_rgb(bg_rgb), .rgb_out(rgb_out), .hsync(hsync),
    .vsync(vsync), .line_tick(line_tick), .frame_tick(frame_tick),
    .frame_count(frame_count)
  );

  vga_timing_compositor #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE_HIGH(1'b1)
  ) dut_hi (
    .clk(clk), .rst_n(rst_n), .ena(ena), .x(xb), .y(yb), .active(active_b),
    .ovl_rgb(ovl_rgb), .bg_rgb(bg_rgb), .rgb_out(rgb_b), .hsync(hsync_b),
    .vsync(vsync_b), .line_tick(lt_b), .frame_tick(ft_b),
    .frame_count(fc_b)
  );

  always #5 clk = ~clk;

  // Expected registered outputs. hs/vs hold the raw in-pulse flag, before polarity is applied.
  typedef struct packed {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic       lt;
    logic       ft;
  } out_t;

  typedef struct {
    int         x;
    int         y;
    logic [5:0] ovl;
    logic [5:0] bg;
    logic [5:0] exp;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;        // enabled clocks since the last reset release
  int   mh = 0;         // model counters
  int   mv = 0;
  out_t sb[$];
  out_t last_e = '0;

  // event logs gathered while running
  logic prev_hs = 1'b1, prev_vs = 1'b1, prev_hsb = 1'b0;
  int   hs_fall[$], hsb_rise[$], vs_fall[$], lt_q[$], ft_q[$];
  int   hs_low0 = 0, hsb_hi0 = 0, vs_low = 0;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d cyc=%0d)",
                              name, act, exp, mh, mv, cyc);
    end
  endtask

  function automatic logic m_act(input int h, input int v);
    return (h < 640) && (v < VA);
  endfunction

  function automatic out_t model(input int h, input int v, input logic [5:0] o, input logic [5:0] b);
    out_t r;
    r.rgb = !m_act(h, v) ? 6'd0 : ((o == KEY) ? b : o);
    r.hs  = (h >= 656) && (h < 752);
    r.vs  = (v >= VA + VF) && (v < VA + VF + VS);
    r.lt  = (h == HT - 1);
    r.ft  = (h == HT - 1) && (v == VT - 1);
    return r;
  endfunction

  task automatic compare_outs(input out_t e);
    check("pins_lo", 32'({rgb_out, hsync, vsync, line_tick, frame_tick}),
                     32'({e.rgb, ~e.hs, ~e.vs, e.lt, e.ft}));
    check("pins_hi", 32'({rgb_b, hsync_b, vsync_b, lt_b, ft_b}),
                     32'({e.rgb, e.hs, e.vs, e.lt, e.ft}));
  endtask

  task automatic monitor();
    if (prev_hs && !hsync)    hs_fall.push_back(cyc);
    if (!prev_hsb && hsync_b) hsb_rise.push_back(cyc);
    if (prev_vs && !vsync)    vs_fall.push_back(cyc);
    if (cyc <= HT && !hsync)  hs_low0++;
    if (cyc <= HT && hsync_b) hsb_hi0++;
    if (!vsync)               vs_low++;
    if (line_tick)            lt_q.push_back(cyc);
    if (frame_tick) begin
      ft_q.push_back(cyc);
      check("ft_at_origin", 32'({x, y, line_tick}), 32'({10'd0, 10'd0, 1'b1}));
    end
    prev_hs  = hsync;
    prev_vs  = vsync;
    prev_hsb = hsync_b;
  endtask

  // One clock. Inputs are applied 1 unit after the previous edge. Outputs are checked 1 unit after this edge.
  task automatic tick(input logic e);
    out_t ex;
    ena = e;
    check("coord", 32'({x, y, active}), 32'({10'(mh), 10'(mv), m_act(mh, mv)}));
    if (e) sb.push_back(model(mh, mv, ovl_rgb, bg_rgb));
    @(posedge clk);
    #1;
    if (e) begin
      cyc++;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      check("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
        ex = sb.pop_front();
        last_e = ex;
      end
      monitor();
    end
    compare_outs(last_e);
  endtask

  task automatic rnd_tick();
    ovl_rgb = ($urandom_range(3) == 0) ? KEY : 6'($urandom);
    bg_rgb  = 6'($urandom);
    tick(1'b1);
  endtask

  task automatic run_to(input int tx, input int ty);
    int budget = 2 * HT * VT;
    while (!(mh == tx && mv == ty) && budget > 0) begin
      rnd_tick();
      budget--;
    end
    check("run_to_reached", 32'({x, y}), 32'({10'(tx), 10'(ty)}));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // keying / blanking vectors, in raster order
    vecs[0] = '{100, 2, 6'b100001, 6'b001100, 6'b001100};  // key -> background
    vecs[1] = '{101, 2, 6'b110110, 6'b001100, 6'b110110};  // opaque overlay
    vecs[2] = '{102, 2, 6'b100001, 6'b100001, 6'b100001};  // bg equal to key passes
    vecs[3] = '{639, 2, 6'b111111, 6'b000111, 6'b111111};  // last visible pixel
    vecs[4] = '{640, 2, 6'b111111, 6'b000111, 6'b000000};  // first blank pixel
    vecs[5] = '{0,   3, 6'b000000, 6'b111111, 6'b000000};  // black overlay is not key
    vecs[6] = '{100, 7, 6'b100000, 6'b000001, 6'b100000};  // near-key is opaque
    vecs[7] = '{5,  VA, 6'b111111, 6'b010101, 6'b000000};  // first blank line

    // reset held
    repeat (3) @(posedge clk);
    #1;
    check("rst_coord", 32'({x, y}), 32'd0);
    check("rst_pins_lo", 32'({rgb_out, hsync, vsync, line_tick, frame_tick, frame_count}),
                         32'({6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));
    check("rst_pins_hi", 32'({hsync_b, vsync_b}), 32'd0);
    rst_n = 1'b1;

    repeat (10) rnd_tick();
    check("after_10", 32'({x, y, active}), 32'({10'd10, 10'd0, 1'b1}));

    foreach (vecs[i]) begin
      run_to(vecs[i].x, vecs[i].y);
      ovl_rgb = vecs[i].ovl;
      bg_rgb  = vecs[i].bg;
      tick(1'b1);
      check("vec_rgb", 32'(rgb_out), 32'(vecs[i].exp));
    end

    // clock-enable pause in the middle of a line
    run_to(300, 9);
    repeat (20) begin
      ovl_rgb = 6'($urandom);
      bg_rgb  = 6'($urandom);
      tick(1'b0);
    end
    check("pause_x", 32'(x), 32'd300);
    rnd_tick();
    check("resume_x", 32'(x), 32'd301);

    // three whole frames from the release point
    while (cyc < 3 * HT * VT) rnd_tick();
    check("frame_count_3", 32'(frame_count), 32'(FC_AFTER_3));
    check("hs_fall_n", 32'(hs_fall.size() >= 2), 32'd1);
    if (hs_fall.size() >= 2) begin
      check("hs_fall0", 32'(hs_fall[0]), 32'd657);
      check("hs_fall1", 32'(hs_fall[1]), 32'd1457);
    end
    check("hs_low_width", 32'(hs_low0), 32'd96);
    check("hsb_rise0", 32'(hsb_rise.size() > 0 ? hsb_rise[0] : -1), 32'd657);
    check("hsb_hi_width", 32'(hsb_hi0), 32'd96);
    check("vs_fall0", 32'(vs_fall.size() > 0 ? vs_fall[0] : -1), 32'(HT * (VA + VF) + 1));
    check("vs_low_total", 32'(vs_low), 32'(3 * VS * HT));
    check("lt_count", 32'(lt_q.size()), 32'(3 * VT));
    check("lt_first", 32'(lt_q.size() > 1 ? lt_q[1] - lt_q[0] : -1), 32'(HT));
    check("ft_count", 32'(ft_q.size()), 32'd3);
    for (int i = 0; i < ft_q.size(); i++)
      check("ft_when", 32'(ft_q[i]), 32'((i + 1) * HT * VT));

    // asynchronous reset mid-frame
    run_to(123, 5);
    rst_n = 1'b0;
    #1;
    check("arst_coord", 32'({x, y}), 32'd0);
    check("arst_pins_lo", 32'({rgb_out, hsync, vsync, line_tick, frame_tick, frame_count}),
                          32'({6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));
    check("arst_pins_hi", 32'({hsync_b, vsync_b}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mh = 0;
    mv = 0;
    cyc = 0;
    sb.delete();
    last_e = '0;
    repeat (5) rnd_tick();
    check("post_rst_x", 32'({x, y}), 32'({10'd5, 10'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
